// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter unit with compressed stepping, return-address stack and misalignment detection
//
// Ports:
//   clk_i, rst_ni        clock; asynchronous active-low reset
//   en_i                 update PC (and RAS) on this edge
//   ilen16_i             current instruction is 16-bit (only when COMPRESSED)
//   sel_mtvec_i/mepc_i   trap entry / trap return target (low bits masked, never fault)
//   sel_ras_i            target = RAS top, pop (sequential if RAS empty)
//   sel_alu_i            target = alu_i
//   add_imm_i            target = base + imm_i, base chosen by sel_pc_base_i
//   ras_push_i           push addr_o onto the RAS
//   addr_o, prev_addr_o  current fetch address and its previous value
//   ras_empty_o/full_o   RAS occupancy
//   misaligned_o         one-cycle pulse per faulting update
//   bad_addr_o           last faulting (unmasked) target
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = 'h8000_0000,
  parameter int              COMPRESSED = 0,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            ilen16_i,
  input  logic            sel_mtvec_i,
  input  logic            sel_mepc_i,
  input  logic            sel_ras_i,
  input  logic            sel_alu_i,
  input  logic            add_imm_i,
  input  logic            sel_pc_base_i,
  input  logic            ras_push_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic [XLEN-1:0] addr_o,
  output logic [XLEN-1:0] prev_addr_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] bad_addr_o
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  // Bits that must be zero in an aligned target.
  localparam logic [XLEN-1:0] LOW_MASK = (COMPRESSED != 0) ? XLEN'(1) : XLEN'(3);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  addr_q, prev_q, bad_q;
  logic             mis_q;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q;   // index of the top entry when count_q != 0
  logic [CNT_W-1:0] count_q;

  logic [XLEN-1:0] step, seq_target, base, target;
  logic            checked, pop, fault;

  always_comb begin
    step       = ((COMPRESSED != 0) && ilen16_i) ? XLEN'(2) : XLEN'(4);
    seq_target = addr_q + step;
    base       = sel_pc_base_i ? prev_q : addr_q;
    target     = seq_target;
    checked    = 1'b0;
    pop        = 1'b0;
    if (sel_mtvec_i) begin
      target = mtvec_i & ~LOW_MASK;
    end else if (sel_mepc_i) begin
      target = mepc_i & ~LOW_MASK;
    end else if (sel_ras_i) begin
      // Empty RAS falls back to the sequential target without popping.
      if (count_q != '0) begin
        target  = ras_mem[top_q];
        checked = 1'b1;
        pop     = 1'b1;
      end
    end else if (sel_alu_i) begin
      target  = alu_i;
      checked = 1'b1;
    end else if (add_imm_i) begin
      target  = base + imm_i;
      checked = 1'b1;
    end
    fault = checked && ((target & LOW_MASK) != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= RESET_ADDR;
      prev_q  <= RESET_ADDR;
      bad_q   <= '0;
      mis_q   <= 1'b0;
      top_q   <= '0;
      count_q <= '0;
    end else if (en_i) begin
      mis_q <= fault;
      if (fault) begin
        bad_q <= target;
      end else begin
        prev_q <= addr_q;
        addr_q <= target;
      end
      // Push+pop replaces the top in place, so pointer and count stay put.
      // A push into a full stack lands on the oldest slot (top+1 wraps onto it).
      case ({ras_push_i, pop})
        2'b10: begin
          top_q <= top_q + PTR_W'(1);
          if (count_q != CNT_FULL) count_q <= count_q + CNT_W'(1);
        end
        2'b01: begin
          top_q   <= top_q - PTR_W'(1);
          count_q <= count_q - CNT_W'(1);
        end
        default: ;
      endcase
    end else begin
      mis_q <= 1'b0;
    end
  end

  // Stack contents need no reset; count_q alone defines validity.
  always_ff @(posedge clk_i) begin
    if (en_i && ras_push_i) begin
      ras_mem[pop ? top_q : top_q + PTR_W'(1)] <= addr_q;
    end
  end

  assign addr_o       = addr_q;
  assign prev_addr_o  = prev_q;
  assign bad_addr_o   = bad_q;
  assign misaligned_o = mis_q;
  assign ras_empty_o  = (count_q == '0);
  assign ras_full_o   = (count_q == CNT_FULL);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen (COMPRESSED=0 and COMPRESSED=1 instances)
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en, ilen16, sel_mtvec, sel_mepc, sel_ras, sel_alu, add_imm, sel_pc_base, ras_push;
  logic [31:0] imm, alu, mtvec, mepc;
  logic [31:0] addr0, prev0, bad0, addr1, prev1, bad1;
  logic        re0, rf0, mis0, re1, rf1, mis1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_ADDR(32'h8000_0000), .COMPRESSED(0), .RAS_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .ilen16_i(ilen16),
    .sel_mtvec_i(sel_mtvec), .sel_mepc_i(sel_mepc), .sel_ras_i(sel_ras), .sel_alu_i(sel_alu),
    .add_imm_i(add_imm), .sel_pc_base_i(sel_pc_base), .ras_push_i(ras_push),
    .imm_i(imm), .alu_i(alu), .mtvec_i(mtvec), .mepc_i(mepc),
    .addr_o(addr0), .prev_addr_o(prev0), .ras_empty_o(re0), .ras_full_o(rf0),
    .misaligned_o(mis0), .bad_addr_o(bad0)
  );

  pc_gen #(.XLEN(32), .RESET_ADDR(32'h8000_0000), .COMPRESSED(1), .RAS_DEPTH(4)) dut_c (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .ilen16_i(ilen16),
    .sel_mtvec_i(sel_mtvec), .sel_mepc_i(sel_mepc), .sel_ras_i(sel_ras), .sel_alu_i(sel_alu),
    .add_imm_i(add_imm), .sel_pc_base_i(sel_pc_base), .ras_push_i(ras_push),
    .imm_i(imm), .alu_i(alu), .mtvec_i(mtvec), .mepc_i(mepc),
    .addr_o(addr1), .prev_addr_o(prev1), .ras_empty_o(re1), .ras_full_o(rf1),
    .misaligned_o(mis1), .bad_addr_o(bad1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 0; ilen16 = 0; sel_mtvec = 0; sel_mepc = 0; sel_ras = 0; sel_alu = 0;
    add_imm = 0; sel_pc_base = 0; ras_push = 0;
    imm = '0; alu = '0; mtvec = '0; mepc = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 0;
    tick();
    tick();
    rst_ni = 1;
  endtask

  // Reset, then four sequential steps: addr=0x80000010, prev=0x8000000C.
  task automatic goto_10();
    do_reset();
    en = 1;
    repeat (4) tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (addr0 !== 32'h8000_0000) begin failures++; $display("FAIL reset_addr got=%h want=%h", addr0, 32'h8000_0000); end
    checks++; if (prev0 !== 32'h8000_0000) begin failures++; $display("FAIL reset_prev got=%h want=%h", prev0, 32'h8000_0000); end
    checks++; if ({re0, rf0, mis0} !== 3'b100) begin failures++; $display("FAIL reset_flags got=%b want=100", {re0, rf0, mis0}); end
    checks++; if (bad0 !== 32'h0) begin failures++; $display("FAIL reset_bad got=%h want=0", bad0); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'h8000_0004; exp_a[1] = 32'h8000_0008; exp_a[2] = 32'h8000_000C;
    do_reset();
    en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (addr0 !== exp_a[i]) begin failures++; $display("FAIL seq_addr%0d got=%h want=%h", i, addr0, exp_a[i]); end
      checks++; if (prev0 !== exp_a[i] - 32'd4) begin failures++; $display("FAIL seq_prev%0d got=%h want=%h", i, prev0, exp_a[i] - 32'd4); end
    end
    idle();
    tick();
    checks++; if (addr0 !== 32'h8000_000C) begin failures++; $display("FAIL en0_hold got=%h want=%h", addr0, 32'h8000_000C); end
  endtask

  task automatic test_compressed();
    do_reset();
    en = 1; ilen16 = 1;
    tick();
    checks++; if (addr1 !== 32'h8000_0002) begin failures++; $display("FAIL c16_addr got=%h want=%h", addr1, 32'h8000_0002); end
    checks++; if (addr0 !== 32'h8000_0004) begin failures++; $display("FAIL nc16_addr got=%h want=%h", addr0, 32'h8000_0004); end
    ilen16 = 0;
    tick();
    checks++; if (addr1 !== 32'h8000_0006) begin failures++; $display("FAIL c32_addr got=%h want=%h", addr1, 32'h8000_0006); end
    checks++; if (addr0 !== 32'h8000_0008) begin failures++; $display("FAIL nc32_addr got=%h want=%h", addr0, 32'h8000_0008); end
    idle();
  endtask

  task automatic test_add_imm();
    goto_10();
    checks++; if ({addr0, prev0} !== {32'h8000_0010, 32'h8000_000C}) begin failures++; $display("FAIL imm_setup got=%h/%h want=80000010/8000000c", addr0, prev0); end
    en = 1; add_imm = 1; sel_pc_base = 1; imm = 32'h20;
    tick();
    checks++; if (addr0 !== 32'h8000_002C) begin failures++; $display("FAIL imm_prevbase got=%h want=%h", addr0, 32'h8000_002C); end
    goto_10();
    en = 1; add_imm = 1; sel_pc_base = 0; imm = 32'h20;
    tick();
    checks++; if (addr0 !== 32'h8000_0030) begin failures++; $display("FAIL imm_pcbase got=%h want=%h", addr0, 32'h8000_0030); end
    goto_10();
    en = 1; add_imm = 1; sel_pc_base = 1; imm = 32'hFFFF_FFFC;
    tick();
    checks++; if (addr0 !== 32'h8000_0008) begin failures++; $display("FAIL imm_neg got=%h want=%h", addr0, 32'h8000_0008); end
    checks++; if (prev0 !== 32'h8000_0010) begin failures++; $display("FAIL imm_neg_prev got=%h want=%h", prev0, 32'h8000_0010); end
    idle();
  endtask

  task automatic test_misaligned();
    goto_10();
    en = 1; sel_alu = 1; alu = 32'h8000_0102;
    tick();
    checks++; if ({addr0, prev0} !== {32'h8000_0010, 32'h8000_000C}) begin failures++; $display("FAIL mis_hold got=%h/%h want=80000010/8000000c", addr0, prev0); end
    checks++; if (mis0 !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b want=1", mis0); end
    checks++; if (bad0 !== 32'h8000_0102) begin failures++; $display("FAIL mis_bad got=%h want=%h", bad0, 32'h8000_0102); end
    checks++; if (addr1 !== 32'h8000_0102 || mis1 !== 1'b0) begin failures++; $display("FAIL c_alu_ok got=%h/%b want=80000102/0", addr1, mis1); end
    en = 0;
    tick();
    checks++; if (mis0 !== 1'b0 || bad0 !== 32'h8000_0102) begin failures++; $display("FAIL mis_end got=%b/%h want=0/80000102", mis0, bad0); end
    en = 1; alu = 32'h8000_0201;
    tick();
    alu = 32'h8000_0303;
    tick();
    checks++; if (mis0 !== 1'b1 || bad0 !== 32'h8000_0303) begin failures++; $display("FAIL mis_b2b got=%b/%h want=1/80000303", mis0, bad0); end
    checks++; if (addr0 !== 32'h8000_0010) begin failures++; $display("FAIL mis_b2b_hold got=%h want=%h", addr0, 32'h8000_0010); end
    en = 0;
    tick();
    checks++; if (mis0 !== 1'b0) begin failures++; $display("FAIL en0_nomis got=%b want=0", mis0); end
    en = 1; sel_mtvec = 1; mtvec = 32'h8000_0103; alu = 32'h8000_0102;
    tick();
    checks++; if (addr0 !== 32'h8000_0100 || mis0 !== 1'b0) begin failures++; $display("FAIL mtvec got=%h/%b want=80000100/0", addr0, mis0); end
    checks++; if (addr1 !== 32'h8000_0102) begin failures++; $display("FAIL c_mtvec got=%h want=%h", addr1, 32'h8000_0102); end
    sel_mtvec = 0; sel_mepc = 1; mepc = 32'h8000_0207;
    tick();
    checks++; if (addr0 !== 32'h8000_0204 || mis0 !== 1'b0) begin failures++; $display("FAIL mepc got=%h/%b want=80000204/0", addr0, mis0); end
    idle();
  endtask

  task automatic test_ras();
    logic [31:0] exp_p [4];
    exp_p[0] = 32'h8000_0010; exp_p[1] = 32'h8000_000C; exp_p[2] = 32'h8000_0008; exp_p[3] = 32'h8000_0004;
    do_reset();
    en = 1; ras_push = 1;
    repeat (3) tick();
    checks++; if (rf0 !== 1'b0 || re0 !== 1'b0) begin failures++; $display("FAIL ras3_flags got=%b%b want=00", re0, rf0); end
    repeat (2) tick();
    checks++; if (rf0 !== 1'b1) begin failures++; $display("FAIL ras_full got=%b want=1", rf0); end
    ras_push = 0; sel_ras = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (addr0 !== exp_p[i] || mis0 !== 1'b0) begin failures++; $display("FAIL ras_pop%0d got=%h want=%h", i, addr0, exp_p[i]); end
    end
    checks++; if (re0 !== 1'b1 || rf0 !== 1'b0) begin failures++; $display("FAIL ras_empty got=%b%b want=10", re0, rf0); end
    tick();
    checks++; if (addr0 !== 32'h8000_0008 || prev0 !== 32'h8000_0004) begin failures++; $display("FAIL ras_empty_pop got=%h/%h want=80000008/80000004", addr0, prev0); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1; ras_push = 1;
    repeat (2) tick();
    sel_ras = 1;
    tick();
    checks++; if (addr0 !== 32'h8000_0004) begin failures++; $display("FAIL pushpop_pc got=%h want=%h", addr0, 32'h8000_0004); end
    checks++; if (re0 !== 1'b0 || rf0 !== 1'b0) begin failures++; $display("FAIL pushpop_flags got=%b%b want=00", re0, rf0); end
    ras_push = 0;
    tick();
    checks++; if (addr0 !== 32'h8000_0008) begin failures++; $display("FAIL pushpop_r got=%h want=%h", addr0, 32'h8000_0008); end
    tick();
    checks++; if (addr0 !== 32'h8000_0000 || re0 !== 1'b1) begin failures++; $display("FAIL pushpop_last got=%h/%b want=80000000/1", addr0, re0); end
    sel_ras = 0; ras_push = 1;
    tick();
    tick();
    #3;
    rst_ni = 0;
    #1;
    checks++; if (addr0 !== 32'h8000_0000 || prev0 !== 32'h8000_0000) begin failures++; $display("FAIL async_rst_addr got=%h/%h want=80000000", addr0, prev0); end
    checks++; if (re0 !== 1'b1 || rf0 !== 1'b0) begin failures++; $display("FAIL async_rst_ras got=%b%b want=10", re0, rf0); end
    idle();
    tick();
    rst_ni = 1;
  endtask

  initial begin
    idle();
    test_reset();
    test_sequential();
    test_compressed();
    test_add_imm();
    test_misaligned();
    test_ras();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
